// File: rtl/tpsram_be.sv
`timescale 1ns/1ps
`default_nettype none
//==============================================================================
// tpsram_be : 1R1W two-port memory, per-byte write enables, LAT-cycle reads,
//             write-first forwarding and optional post-reset clear engine.
// Rev 1.0
//==============================================================================
module tpsram_be #(
   parameter int W              = 32,
   parameter int N              = 128,
   parameter int LAT            = 1,
   parameter int CLEAR_ON_RESET = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   output logic                 init_busy,
   input  logic                 wr_en,
   input  logic [$clog2(N)-1:0] wr_addr,
   input  logic [W-1:0]         wr_data,
   input  logic [W/8-1:0]       wr_be,
   input  logic                 rd_en,
   input  logic [$clog2(N)-1:0] rd_addr,
   output logic                 rd_valid,
   output logic [W-1:0]         rd_data
);

   localparam int B = W / 8;
   localparam int A = $clog2(N);

   localparam logic [A:0]   c_DEPTH = (A + 1)'(N);
   localparam logic [A-1:0] c_LAST  = A'(N - 1);

   generate
      if (W % 8 != 0) begin : g_chk_width
         $fatal(1, "tpsram_be: W must be a multiple of 8");
      end
      if (LAT < 1 || LAT > 3) begin : g_chk_lat
         $fatal(1, "tpsram_be: LAT must be in 1..3");
      end
      if (N < 2) begin : g_chk_depth
         $fatal(1, "tpsram_be: N must be at least 2");
      end
   endgenerate

   typedef enum logic [0:0] {
      S_CLEAR = 1'b0,
      S_READY = 1'b1
   } state_t;

   localparam state_t c_RESET_STATE = (CLEAR_ON_RESET != 0) ? S_CLEAR : S_READY;

   state_t           r_state;
   logic [A-1:0]     r_cnt;
   logic             r_init_busy;
   logic [W-1:0]     r_mem [N];
   logic [LAT-1:0]   r_pv;
   logic [W-1:0]     r_pd [LAT];

   logic             w_ready;
   logic             w_wr_inrange;
   logic             w_rd_inrange;
   logic             w_wr_ok;
   logic             w_rd_ok;
   logic             w_fwd;
   logic [W-1:0]     w_rd_word;

   assign w_ready      = (r_state == S_READY);
   assign w_wr_inrange = ({1'b0, wr_addr} < c_DEPTH);
   assign w_rd_inrange = ({1'b0, rd_addr} < c_DEPTH);
   assign w_wr_ok      = w_ready && wr_en && w_wr_inrange;
   assign w_rd_ok      = w_ready && rd_en;
   assign w_fwd        = w_wr_ok && (wr_addr == rd_addr);

   // Clear sequencer: one word per cycle, READY once word N-1 has been zeroed.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= c_RESET_STATE;
         r_cnt       <= '0;
         r_init_busy <= (CLEAR_ON_RESET != 0);
      end else begin
         case (r_state)
            S_CLEAR: begin
               if (r_cnt == c_LAST) begin
                  r_state     <= S_READY;
                  r_init_busy <= 1'b0;
                  r_cnt       <= '0;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_READY: begin
               r_state <= S_READY;
            end
            default: begin
               r_state <= c_RESET_STATE;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (r_state == S_CLEAR) begin
         r_mem[r_cnt] <= '0;
      end else if (w_wr_ok) begin
         for (int i = 0; i < B; i++) begin
            if (wr_be[i]) begin
               r_mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
            end
         end
      end
   end

   // Write-first: a same-cycle write to the read address shows through per byte.
   always_comb begin
      w_rd_word = '0;
      if (w_rd_inrange) begin
         w_rd_word = r_mem[rd_addr];
         for (int i = 0; i < B; i++) begin
            if (w_fwd && wr_be[i]) begin
               w_rd_word[8*i +: 8] = wr_data[8*i +: 8];
            end
         end
      end
   end

   // Data stages only advance with their valid so rd_data holds the last word.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pv <= '0;
         for (int i = 0; i < LAT; i++) begin
            r_pd[i] <= '0;
         end
      end else begin
         r_pv[0] <= w_rd_ok;
         if (w_rd_ok) begin
            r_pd[0] <= w_rd_word;
         end
         for (int i = 1; i < LAT; i++) begin
            r_pv[i] <= r_pv[i-1];
            if (r_pv[i-1]) begin
               r_pd[i] <= r_pd[i-1];
            end
         end
      end
   end

   assign init_busy = r_init_busy;
   assign rd_valid  = r_pv[LAT-1];
   assign rd_data   = r_pd[LAT-1];

endmodule
`default_nettype wire

// File: tb/tb_tpsram_be.sv
`timescale 1ns/1ps
`default_nettype none
//==============================================================================
// tb_tpsram_be : scoreboard bench for tpsram_be (W=32, N=16, LAT=2, clear on).
// Rev 1.0
//==============================================================================
module tb_tpsram_be;

   localparam int W   = 32;
   localparam int N   = 16;
   localparam int LAT = 2;

   logic          clk;
   logic          rst;
   logic          init_busy;
   logic          wr_en;
   logic [3:0]    wr_addr;
   logic [31:0]   wr_data;
   logic [3:0]    wr_be;
   logic          rd_en;
   logic [3:0]    rd_addr;
   logic          rd_valid;
   logic [31:0]   rd_data;

   typedef struct {
      logic [31:0] d;
      int          due;
   } exp_t;

   exp_t sb [$];
   int   cyc    = 0;
   int   n_cmp  = 0;
   int   n_bad  = 0;

   tpsram_be #(
      .W              (W),
      .N              (N),
      .LAT            (LAT),
      .CLEAR_ON_RESET (1)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .init_busy (init_busy),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .wr_be     (wr_be),
      .rd_en     (rd_en),
      .rd_addr   (rd_addr),
      .rd_valid  (rd_valid),
      .rd_data   (rd_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Monitor: every rd_valid must match the oldest queued expectation, on time.
   always @(negedge clk) begin
      if (rd_valid) begin
         if (rst || sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL rd_unexpected: got rd_valid=1 data %h, expected no response (cycle %0d)",
                     rd_data, cyc);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("rd_data", rd_data, e.d);
            check("rd_latency_cycle", 32'(cyc), 32'(e.due));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic we, input logic [3:0] wa, input logic [31:0] wd,
                        input logic [3:0] be, input logic re, input logic [3:0] ra,
                        input logic push, input logic [31:0] expd);
      wr_en   = we;
      wr_addr = wa;
      wr_data = wd;
      wr_be   = be;
      rd_en   = re;
      rd_addr = ra;
      if (push) sb.push_back('{d: expd, due: cyc + LAT});
      tick();
      wr_en = 1'b0;
      rd_en = 1'b0;
   endtask

   task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
      drive(1'b1, a, d, be, 1'b0, 4'd0, 1'b0, 32'd0);
   endtask

   task automatic rd(input logic [3:0] a, input logic [31:0] expd);
      drive(1'b0, 4'd0, 32'd0, 4'd0, 1'b1, a, 1'b1, expd);
   endtask

   task automatic drain(input string nm);
      int i;
      i = 0;
      while (sb.size() != 0 && i < 20) begin
         tick();
         i++;
      end
      n_cmp++;
      if (sb.size() != 0) begin
         n_bad++;
         $display("FAIL %s: got %0d responses outstanding, expected 0", nm, sb.size());
         sb.delete();
      end
   endtask

   task automatic count_busy(input string nm);
      int n;
      n = 0;
      while (init_busy && n < 40) begin
         n++;
         tick();
      end
      check(nm, 32'(n), 32'd16);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got simulation still running, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      rst     = 1'b1;
      wr_en   = 1'b0;
      wr_addr = '0;
      wr_data = '0;
      wr_be   = '0;
      rd_en   = 1'b0;
      rd_addr = '0;
      repeat (3) tick();

      check("reset_rd_valid", {31'd0, rd_valid}, 32'd0);
      check("reset_rd_data", rd_data, 32'd0);
      check("reset_init_busy", {31'd0, init_busy}, 32'd1);

      // Release reset; drop a write and a read into the clear window.
      rst = 1'b0;
      n = 0;
      while (init_busy && n < 40) begin
         n++;
         if (n == 4)      wr(4'd2, 32'h12345678, 4'hF);
         else if (n == 5) drive(1'b0, 4'd0, 32'd0, 4'd0, 1'b1, 4'd4, 1'b0, 32'd0);
         else             tick();
      end
      check("init_busy_len", 32'(n), 32'd16);

      rd(4'd5, 32'h00000000);
      rd(4'd2, 32'h00000000);
      drain("drain_init");

      wr(4'd3, 32'hAABBCCDD, 4'b1111);
      wr(4'd3, 32'h11223344, 4'b0101);
      rd(4'd3, 32'hAA22CC44);
      wr(4'd6, 32'hCAFEF00D, 4'b0000);
      rd(4'd6, 32'h00000000);
      drain("drain_byte_enable");

      drive(1'b1, 4'd7, 32'hDEADBEEF, 4'b0011, 1'b1, 4'd7, 1'b1, 32'h0000BEEF);
      wr(4'd7, 32'hFFFFFFFF, 4'b1111);
      drain("drain_forward");
      rd(4'd7, 32'hFFFFFFFF);
      drain("drain_forward_after");

      for (int k = 0; k < 16; k++) wr(4'(k), k * 32'h01010101, 4'hF);
      for (int k = 0; k < 16; k++) rd(4'(k), k * 32'h01010101);
      drain("drain_burst");
      check("hold_rd_valid", {31'd0, rd_valid}, 32'd0);
      check("hold_rd_data", rd_data, 32'h0F0F0F0F);

      // Reset with a read in flight, then again part-way through the clear.
      rd(4'd9, 32'h09090909);
      rst = 1'b1;
      sb.delete();
      #1;
      check("midrst_rd_valid", {31'd0, rd_valid}, 32'd0);
      check("midrst_rd_data", rd_data, 32'd0);
      check("midrst_init_busy", {31'd0, init_busy}, 32'd1);
      repeat (2) tick();
      rst = 1'b0;
      repeat (8) tick();
      check("clear_mid_busy", {31'd0, init_busy}, 32'd1);
      rst = 1'b1;
      repeat (2) tick();
      rst = 1'b0;
      count_busy("reclear_busy_len");
      rd(4'd5, 32'h00000000);
      rd(4'd15, 32'h00000000);
      drain("drain_reclear");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
